// File: rtl/sram_like_arbiter_if.sv
// SRAM-like request/response bus shared by the CPU masters and the downstream bridge port.
// The master drives the request phase; the slave answers with addr_ok/data_ok/rdata.
interface sram_like_arbiter_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  modport master (
    output req, wr, size, wstrb, addr, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, wstrb, addr, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/sram_like_arbiter.sv
// Shares one SRAM-like port between the instruction and data masters: fixed-priority grant with
// lock until acceptance, and an in-order ID FIFO that routes each response to its issuer.
module sram_like_arbiter #(
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter bit          DATA_FIRST      = 1'b1
) (
  input  logic                       clk,
  input  logic                       reset,
  sram_like_arbiter_if.slave         inst,
  sram_like_arbiter_if.slave         data,
  sram_like_arbiter_if.master        mem,
  output logic                       err_spurious
);

  localparam int unsigned PtrW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CntW = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic {
    IdInst = 1'b0,
    IdData = 1'b1
  } master_id_e;

  logic            lock_valid_q;
  master_id_e      lock_id_q;
  master_id_e      id_q [MAX_OUTSTANDING];
  logic [PtrW-1:0] wr_ptr_q;
  logic [PtrW-1:0] rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic            err_q;

  logic       grant_valid;
  master_id_e grant_id;
  logic       granted_req;
  logic       full;
  logic       push;
  logic       pop;
  master_id_e pop_id;

  // A pending (unaccepted) request keeps the bus, even if its master withdraws it.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = IdInst;
    if (reset) begin
      grant_valid = 1'b0;
    end else if (lock_valid_q) begin
      grant_valid = 1'b1;
      grant_id    = lock_id_q;
    end else if (inst.req && data.req) begin
      grant_valid = 1'b1;
      grant_id    = DATA_FIRST ? IdData : IdInst;
    end else if (data.req) begin
      grant_valid = 1'b1;
      grant_id    = IdData;
    end else if (inst.req) begin
      grant_valid = 1'b1;
      grant_id    = IdInst;
    end
  end

  assign granted_req = grant_valid && ((grant_id == IdData) ? data.req : inst.req);
  assign full        = (count_q == CntW'(MAX_OUTSTANDING));

  assign mem.req = granted_req && !full && !reset;

  always_comb begin
    mem.wr    = 1'b0;
    mem.size  = 2'b00;
    mem.wstrb = 4'b0000;
    mem.addr  = 32'h0;
    mem.wdata = 32'h0;
    if (grant_valid) begin
      if (grant_id == IdData) begin
        mem.wr    = data.wr;
        mem.size  = data.size;
        mem.wstrb = data.wstrb;
        mem.addr  = data.addr;
        mem.wdata = data.wdata;
      end else begin
        mem.wr    = inst.wr;
        mem.size  = inst.size;
        mem.wstrb = inst.wstrb;
        mem.addr  = inst.addr;
        mem.wdata = inst.wdata;
      end
    end
  end

  assign push = mem.req && mem.addr_ok;
  assign pop  = !reset && mem.data_ok && (count_q != '0);

  assign pop_id = id_q[rd_ptr_q];

  assign inst.addr_ok = push && (grant_id == IdInst);
  assign data.addr_ok = push && (grant_id == IdData);
  assign inst.data_ok = pop && (pop_id == IdInst);
  assign data.data_ok = pop && (pop_id == IdData);
  assign inst.rdata   = reset ? 32'h0 : mem.rdata;
  assign data.rdata   = reset ? 32'h0 : mem.rdata;

  assign err_spurious = err_q && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      lock_valid_q <= 1'b0;
      lock_id_q    <= IdInst;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      err_q        <= 1'b0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        id_q[i] <= IdInst;
      end
    end else begin
      if (push) begin
        lock_valid_q <= 1'b0;
      end else if (mem.req) begin
        lock_valid_q <= 1'b1;
        lock_id_q    <= grant_id;
      end

      if (push) begin
        id_q[wr_ptr_q] <= grant_id;
        wr_ptr_q       <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end

      if (push && !pop) begin
        count_q <= count_q + CntW'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CntW'(1);
      end

      if (mem.data_ok && (count_q == '0)) begin
        err_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed bench for sram_like_arbiter (MAX_OUTSTANDING=4, DATA_FIRST=1): inputs change just after
// the rising edge, combinational outputs are checked on the falling edge.
module tb_sram_like_arbiter;

  logic clk;
  logic reset;
  logic err_spurious;
  int   n_checks;
  int   n_fail;

  sram_like_arbiter_if inst_if ();
  sram_like_arbiter_if data_if ();
  sram_like_arbiter_if mem_if ();

  sram_like_arbiter #(
    .MAX_OUTSTANDING(4),
    .DATA_FIRST     (1'b1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .inst        (inst_if),
    .data        (data_if),
    .mem         (mem_if),
    .err_spurious(err_spurious)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drv_inst(input logic req, input logic [31:0] addr);
    inst_if.req   = req;
    inst_if.wr    = 1'b0;
    inst_if.size  = 2'd2;
    inst_if.wstrb = 4'hf;
    inst_if.addr  = addr;
    inst_if.wdata = 32'h0;
  endtask

  task automatic drv_data(input logic req, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata);
    data_if.req   = req;
    data_if.wr    = wr;
    data_if.size  = 2'd2;
    data_if.wstrb = wr ? 4'h3 : 4'h0;
    data_if.addr  = addr;
    data_if.wdata = wdata;
  endtask

  task automatic drv_mem(input logic addr_ok, input logic data_ok, input logic [31:0] rdata);
    mem_if.addr_ok = addr_ok;
    mem_if.data_ok = data_ok;
    mem_if.rdata   = rdata;
  endtask

  task automatic idle();
    drv_inst(1'b0, 32'h0);
    drv_data(1'b0, 1'b0, 32'h0, 32'h0);
    drv_mem(1'b0, 1'b0, 32'h0);
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    idle();

    // Reset: everything quiet even with live inputs.
    drv_inst(1'b1, 32'h0000_1234);
    drv_mem(1'b1, 1'b1, 32'hdead_beef);
    settle();
    next_cycle();
    settle();
    chk("rst_mem_req", 32'(mem_if.req), 32'd0);
    chk("rst_inst_addr_ok", 32'(inst_if.addr_ok), 32'd0);
    chk("rst_mem_addr", mem_if.addr, 32'h0);
    chk("rst_inst_data_ok", 32'(inst_if.data_ok), 32'd0);
    chk("rst_inst_rdata", inst_if.rdata, 32'h0);
    chk("rst_err", 32'(err_spurious), 32'd0);
    next_cycle();
    reset = 1'b0;
    idle();

    // Inst-only read.
    drv_inst(1'b1, 32'hbfc0_0000);
    drv_mem(1'b1, 1'b0, 32'h0);
    settle();
    chk("t1_mem_req", 32'(mem_if.req), 32'd1);
    chk("t1_mem_addr", mem_if.addr, 32'hbfc0_0000);
    chk("t1_mem_size", 32'(mem_if.size), 32'd2);
    chk("t1_mem_wstrb", 32'(mem_if.wstrb), 32'hf);
    chk("t1_inst_addr_ok", 32'(inst_if.addr_ok), 32'd1);
    chk("t1_data_addr_ok", 32'(data_if.addr_ok), 32'd0);
    next_cycle();
    idle();
    settle();
    chk("t1_idle_mem_req", 32'(mem_if.req), 32'd0);
    next_cycle();
    drv_mem(1'b0, 1'b1, 32'h3c1d_0001);
    settle();
    chk("t1_inst_data_ok", 32'(inst_if.data_ok), 32'd1);
    chk("t1_inst_rdata", inst_if.rdata, 32'h3c1d_0001);
    chk("t1_data_data_ok", 32'(data_if.data_ok), 32'd0);
    next_cycle();
    idle();
    settle();
    chk("t1_err", 32'(err_spurious), 32'd0);
    next_cycle();

    // Simultaneous requests: data first, responses in order.
    drv_inst(1'b1, 32'h0000_1000);
    drv_data(1'b1, 1'b1, 32'h0000_2000, 32'h0000_55aa);
    drv_mem(1'b1, 1'b0, 32'h0);
    settle();
    chk("t2_data_addr_ok", 32'(data_if.addr_ok), 32'd1);
    chk("t2_inst_addr_ok0", 32'(inst_if.addr_ok), 32'd0);
    chk("t2_mem_addr0", mem_if.addr, 32'h0000_2000);
    chk("t2_mem_wr", 32'(mem_if.wr), 32'd1);
    chk("t2_mem_wdata", mem_if.wdata, 32'h0000_55aa);
    chk("t2_mem_wstrb", 32'(mem_if.wstrb), 32'h3);
    next_cycle();
    drv_data(1'b0, 1'b0, 32'h0, 32'h0);
    settle();
    chk("t2_inst_addr_ok1", 32'(inst_if.addr_ok), 32'd1);
    chk("t2_mem_addr1", mem_if.addr, 32'h0000_1000);
    chk("t2_mem_wr1", 32'(mem_if.wr), 32'd0);
    next_cycle();
    idle();
    drv_mem(1'b0, 1'b1, 32'h1111_1111);
    settle();
    chk("t2_resp0_data", 32'(data_if.data_ok), 32'd1);
    chk("t2_resp0_inst", 32'(inst_if.data_ok), 32'd0);
    chk("t2_resp0_rdata", data_if.rdata, 32'h1111_1111);
    next_cycle();
    drv_mem(1'b0, 1'b1, 32'h2222_2222);
    settle();
    chk("t2_resp1_inst", 32'(inst_if.data_ok), 32'd1);
    chk("t2_resp1_data", 32'(data_if.data_ok), 32'd0);
    chk("t2_resp1_rdata", inst_if.rdata, 32'h2222_2222);
    next_cycle();
    idle();

    // Lock: data held 3 cycles while inst also requests.
    drv_data(1'b1, 1'b0, 32'h0000_3000, 32'h0);
    drv_inst(1'b1, 32'h0000_4000);
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("t3_lock_mem_addr", mem_if.addr, 32'h0000_3000);
      chk("t3_lock_mem_req", 32'(mem_if.req), 32'd1);
      chk("t3_lock_inst_addr_ok", 32'(inst_if.addr_ok), 32'd0);
      next_cycle();
    end
    drv_mem(1'b1, 1'b0, 32'h0);
    settle();
    chk("t3_accept_data", 32'(data_if.addr_ok), 32'd1);
    chk("t3_accept_addr", mem_if.addr, 32'h0000_3000);
    next_cycle();
    drv_data(1'b0, 1'b0, 32'h0, 32'h0);
    settle();
    chk("t3_inst_after", 32'(inst_if.addr_ok), 32'd1);
    chk("t3_inst_addr", mem_if.addr, 32'h0000_4000);
    next_cycle();

    // Locked master withdraws: bus stays idle, other master not granted.
    drv_inst(1'b0, 32'h0);
    drv_data(1'b1, 1'b0, 32'h0000_5000, 32'h0);
    drv_mem(1'b0, 1'b0, 32'h0);
    settle();
    chk("t3b_lock_req", 32'(mem_if.req), 32'd1);
    next_cycle();
    drv_data(1'b0, 1'b0, 32'h0000_5000, 32'h0);
    drv_inst(1'b1, 32'h0000_6000);
    drv_mem(1'b1, 1'b0, 32'h0);
    settle();
    chk("t3b_drop_mem_req", 32'(mem_if.req), 32'd0);
    chk("t3b_drop_inst_ok", 32'(inst_if.addr_ok), 32'd0);
    chk("t3b_drop_addr", mem_if.addr, 32'h0000_5000);
    next_cycle();
    drv_data(1'b1, 1'b0, 32'h0000_5000, 32'h0);
    settle();
    chk("t3b_data_ok", 32'(data_if.addr_ok), 32'd1);
    next_cycle();
    drv_data(1'b0, 1'b0, 32'h0, 32'h0);
    settle();
    chk("t3b_inst_ok", 32'(inst_if.addr_ok), 32'd1);
    chk("t3b_inst_addr", mem_if.addr, 32'h0000_6000);
    next_cycle();
    idle();

    // Drain: order data, inst, data, inst.
    for (int i = 0; i < 4; i++) begin
      drv_mem(1'b0, 1'b1, 32'(i));
      settle();
      chk("t3_drain_data_ok", 32'(data_if.data_ok), ((i % 2) == 0) ? 32'd1 : 32'd0);
      chk("t3_drain_inst_ok", 32'(inst_if.data_ok), ((i % 2) == 1) ? 32'd1 : 32'd0);
      next_cycle();
    end
    idle();

    // Full: four accepted, fifth refused; a pop does not admit a same-cycle push.
    drv_inst(1'b1, 32'h0000_7000);
    drv_mem(1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("t4_fill_addr_ok", 32'(inst_if.addr_ok), 32'd1);
      next_cycle();
    end
    settle();
    chk("t4_full_mem_req", 32'(mem_if.req), 32'd0);
    chk("t4_full_addr_ok", 32'(inst_if.addr_ok), 32'd0);
    next_cycle();
    drv_mem(1'b1, 1'b1, 32'h0000_00aa);
    settle();
    chk("t4_pop_data_ok", 32'(inst_if.data_ok), 32'd1);
    chk("t4_pop_mem_req", 32'(mem_if.req), 32'd0);
    chk("t4_pop_addr_ok", 32'(inst_if.addr_ok), 32'd0);
    next_cycle();
    drv_mem(1'b1, 1'b0, 32'h0);
    settle();
    chk("t4_refill_mem_req", 32'(mem_if.req), 32'd1);
    chk("t4_refill_addr_ok", 32'(inst_if.addr_ok), 32'd1);
    next_cycle();
    idle();
    for (int i = 0; i < 4; i++) begin
      drv_mem(1'b0, 1'b1, 32'h0);
      settle();
      chk("t4_drain_inst_ok", 32'(inst_if.data_ok), 32'd1);
      next_cycle();
    end
    idle();

    // Spurious response on empty FIFO.
    drv_mem(1'b0, 1'b1, 32'h0bad_0bad);
    settle();
    chk("t5_spur_inst_ok", 32'(inst_if.data_ok), 32'd0);
    chk("t5_spur_data_ok", 32'(data_if.data_ok), 32'd0);
    next_cycle();
    idle();
    settle();
    chk("t5_err_set", 32'(err_spurious), 32'd1);
    next_cycle();
    next_cycle();
    settle();
    chk("t5_err_sticky", 32'(err_spurious), 32'd1);
    next_cycle();

    // Reset with two outstanding: FIFO discarded, late responses are spurious.
    drv_inst(1'b1, 32'h0000_8000);
    drv_mem(1'b1, 1'b0, 32'h0);
    next_cycle();
    next_cycle();
    reset = 1'b1;
    settle();
    chk("t6_rst_mem_req", 32'(mem_if.req), 32'd0);
    chk("t6_rst_err", 32'(err_spurious), 32'd0);
    next_cycle();
    reset = 1'b0;
    idle();
    settle();
    chk("t6_err_cleared", 32'(err_spurious), 32'd0);
    next_cycle();
    drv_mem(1'b0, 1'b1, 32'h0);
    settle();
    chk("t6_late_inst_ok", 32'(inst_if.data_ok), 32'd0);
    next_cycle();
    idle();
    settle();
    chk("t6_late_err", 32'(err_spurious), 32'd1);
    next_cycle();
    drv_data(1'b1, 1'b0, 32'h0000_9000, 32'h0);
    drv_mem(1'b1, 1'b0, 32'h0);
    settle();
    chk("t6_new_addr_ok", 32'(data_if.addr_ok), 32'd1);
    chk("t6_new_addr", mem_if.addr, 32'h0000_9000);
    next_cycle();
    idle();
    drv_mem(1'b0, 1'b1, 32'h1234_5678);
    settle();
    chk("t6_new_data_ok", 32'(data_if.data_ok), 32'd1);
    chk("t6_new_inst_ok", 32'(inst_if.data_ok), 32'd0);
    next_cycle();
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
